// File: rtl/pipe_reg_chain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and helpers for the pipe_reg_chain block:
//                occupancy-width function, default bubble-counter width and
//                a popcount helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default width of the saturating bubble counter.
    localparam int unsigned DEFAULT_CNT_W = 16;

    // Widest stage-valid vector popcount() can take. This also caps DEPTH.
    localparam int unsigned POP_MAX_W = 64;

    // Bits needed to hold a count from 0 to depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Number of set bits. Callers zero-extend narrower vectors to 64 bits.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg_chain_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg_chain_if
//  Description : Bundle of the handshake, control and observation signals of
//                pipe_reg_chain. The master side drives the stage-0 payload
//                and the stall/flush vectors; the slave side (the chain)
//                returns in_ready, per-stage state, the output stage,
//                occupancy and the bubble count.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_reg_chain_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int OCC_W = occ_width(DEPTH);

    logic                     in_valid;     // payload presented at stage 0
    logic [WIDTH-1:0]         in_data;      // stage-0 payload
    logic                     in_ready;     // stage 0 accepts this cycle
    logic [DEPTH-1:0]         stall;        // per-stage stall request
    logic [DEPTH-1:0]         flush;        // per-stage kill request
    logic [DEPTH-1:0]         stage_valid;  // valid bit of every stage
    logic [DEPTH*WIDTH-1:0]   stage_data;   // stage i at [i*WIDTH +: WIDTH]
    logic                     out_valid;    // valid of stage DEPTH-1
    logic [WIDTH-1:0]         out_data;     // payload of stage DEPTH-1
    logic [OCC_W-1:0]         occupancy;    // number of valid stages
    logic [CNT_W-1:0]         bubble_cnt;   // saturating bubble count

    modport master (
        output in_valid, in_data, stall, flush,
        input  in_ready, stage_valid, stage_data, out_valid, out_data,
               occupancy, bubble_cnt
    );

    modport slave (
        input  in_valid, in_data, stall, flush,
        output in_ready, stage_valid, stage_data, out_valid, out_data,
               occupancy, bubble_cnt
    );

endinterface
`default_nettype wire

// File: rtl/pipe_reg_chain_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage
//  Description : One pipeline register with a valid bit.
//                Ports: clk, reset (async, active-high), i_en (load),
//                i_clr (kill: flush or bubble, beats i_en), i_valid/i_data
//                (source), o_valid/o_data (register contents).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int WIDTH      = 32,
    parameter int CLEAR_DATA = 1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_en,
    input  wire logic             i_clr,
    input  wire logic             i_valid,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clr) begin
            // Kill drops valid; payload is only scrubbed when asked to.
            r_valid <= 1'b0;
            if (CLEAR_DATA != 0) begin
                r_data <= '0;
            end
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg_chain
//  Description : Parametrised chain of DEPTH pipeline registers with valid
//                bits, stall propagation (hold chain), per-stage flush,
//                bubble insertion and a saturating bubble counter.
//                Ports: clk, reset (async, active-high), bus (slave side of
//                pipe_reg_chain_if carrying in/out handshake, stall/flush,
//                stage state, occupancy and bubble_cnt). DEPTH <= 64.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  wire logic        clk,
    input  wire logic        reset,
    pipe_reg_chain_if.slave  bus
);

    localparam int OCC_W = occ_width(DEPTH);
    localparam int SUM_W = CNT_W + OCC_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [DEPTH-1:0] w_hold;
    logic [DEPTH-1:0] w_bubble;
    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [OCC_W-1:0] w_nbub;
    logic [SUM_W-1:0] w_cnt_sum;
    logic [CNT_W-1:0] w_cnt_next;
    logic [POP_MAX_W-1:0] w_valid_ext;
    logic [POP_MAX_W-1:0] w_bubble_ext;
    logic [CNT_W-1:0] r_bubble_cnt;

    // A stage is held when it or any stage closer to the output stalls.
    // Written as an OR over the downstream stall bits rather than a
    // recursive chain so the logic has no self-referencing vector.
    always_comb begin
        w_hold = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic h;
            h = 1'b0;
            for (int j = i; j < DEPTH; j++) begin
                h = h | bus.stall[j];
            end
            w_hold[i] = h;
        end
    end

    // A bubble enters stage i when it is free to move but its source is
    // frozen. A flush on the same stage wins and is not counted.
    always_comb begin
        w_bubble = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_bubble[i] = w_hold[i-1] & ~w_hold[i] & ~bus.flush[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                pipe_stage #(
                    .WIDTH      (WIDTH),
                    .CLEAR_DATA (CLEAR_DATA)
                ) u_stage (
                    .clk     (clk),
                    .reset   (reset),
                    .i_en    (~w_hold[0]),
                    .i_clr   (bus.flush[0]),
                    .i_valid (bus.in_valid),
                    .i_data  (bus.in_data),
                    .o_valid (w_valid[0]),
                    .o_data  (w_data[0])
                );
            end else begin : g_body
                pipe_stage #(
                    .WIDTH      (WIDTH),
                    .CLEAR_DATA (CLEAR_DATA)
                ) u_stage (
                    .clk     (clk),
                    .reset   (reset),
                    .i_en    (~w_hold[gi]),
                    .i_clr   (bus.flush[gi] | w_bubble[gi]),
                    .i_valid (w_valid[gi-1]),
                    .i_data  (w_data[gi-1]),
                    .o_valid (w_valid[gi]),
                    .o_data  (w_data[gi])
                );
            end
            assign bus.stage_data[gi*WIDTH +: WIDTH] = w_data[gi];
        end
    endgenerate

    always_comb begin
        w_valid_ext  = '0;
        w_bubble_ext = '0;
        w_valid_ext[DEPTH-1:0]  = w_valid;
        w_bubble_ext[DEPTH-1:0] = w_bubble;
    end

    // Saturating add of this cycle's bubble count; the sum is computed one
    // OCC_W wider so overflow is visible before clamping.
    always_comb begin
        w_nbub     = OCC_W'(popcount(w_bubble_ext));
        w_cnt_sum  = SUM_W'(r_bubble_cnt) + SUM_W'(w_nbub);
        w_cnt_next = (w_cnt_sum > SUM_W'(c_CNT_MAX)) ? c_CNT_MAX
                                                     : w_cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else begin
            r_bubble_cnt <= w_cnt_next;
        end
    end

    assign bus.in_ready    = ~w_hold[0];
    assign bus.stage_valid = w_valid;
    assign bus.out_valid   = w_valid[DEPTH-1];
    assign bus.out_data    = w_data[DEPTH-1];
    assign bus.occupancy   = OCC_W'(popcount(w_valid_ext));
    assign bus.bubble_cnt  = r_bubble_cnt;

endmodule
`default_nettype wire

// File: doc/pipe_reg_chain.md
# pipe_reg_chain

Parametrised pipeline-register chain with per-stage valid bits, stall propagation, flush and bubble insertion. It replaces hand-instantiated rows of plain pipeline flops between datapath stages (F→D→E→M→WB). Stalls and flushes from the hazard logic act directly on the stage registers. The block also counts the bubbles it inserts, for performance monitoring.

## Interface
Parameters:
- WIDTH, 32, payload bits per stage.
- DEPTH, 4, number of register stages (≥1); stage 0 is youngest, stage DEPTH-1 drives the output.
- CLEAR_DATA, 1, when 1 the payload is zeroed on flush and bubble; when 0 the payload keeps its old value and only valid drops.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  payload presented at stage-0 input.
- in_data  in  WIDTH  payload.
- in_ready  out  1  stage 0 accepts this cycle; equals ~hold[0].
- stall  in  DEPTH  stall[i]=1 forces stage i to keep its contents.
- flush  in  DEPTH  flush[i]=1 kills stage i next cycle.
- stage_valid  out  DEPTH  valid bit of every stage.
- stage_data  out  DEPTH*WIDTH  all stage payloads; stage i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  stage_valid[DEPTH-1].
- out_data  out  WIDTH  payload of stage DEPTH-1.
- occupancy  out  $clog2(DEPTH+1)  popcount of stage_valid (combinational).
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles.

## Operation
- Hold chain (combinational):
  - hold[DEPTH-1] = stall[DEPTH-1].
  - hold[i] = stall[i] | hold[i+1].
  - A stall freezes its own stage and every older-input stage below it.
- Per stage i, per clock, in priority order:
  1. flush[i]: valid←0; data←0 if CLEAR_DATA.
  2. hold[i]: valid and data unchanged.
  3. Otherwise load from the source: stage i-1, or the input for i=0.
     - Stage 0 loads valid←in_valid, data←in_data.
     - Stage i>0 whose source is held (hold[i-1]=1, hold[i]=0) loads a bubble: valid←0, data←0 if CLEAR_DATA.
- Flush beats stall on the same stage. Flush of stage i does not affect other stages; the caller asserts each bit it needs (e.g. branch in M flushes D and E).
- Input handshake:
  - The transfer occurs when in_valid & in_ready.
  - When in_ready=0 the source holds in_data; the block ignores it.
  - flush[0] with in_ready=1 discards the input (stage 0 becomes invalid).
- bubble_cnt increments by the number of stages loading a bubble this cycle, saturating at 2^CNT_W-1. A flush is not a bubble. Invalid data from an empty source is not a bubble.
- No collapsing of bubbles: an invalid stage that is held stays held.

## Timing
- Reset (async assert, clocked release): all stage_valid=0, all stage_data=0, bubble_cnt=0, occupancy=0. in_ready reflects ~hold[0] combinationally (1 if stall=0).
- Latency with no stall/flush: in_data at edge n appears on out_data after edge n+DEPTH-1, i.e. DEPTH edges from input to the output register.
- Throughput: one payload per cycle.
- stall/flush are sampled at the same edge they act on; effect visible the next cycle.
- Reset asserted mid-operation clears everything immediately, independent of clk; in-flight payloads are lost.
- Simultaneous stall[i] and flush[i+1]: stage i holds; stage i+1 is flushed (same result as the bubble). bubble_cnt does not count it.
- DEPTH=1: the hold chain degenerates to stall[0]; bubbles are impossible.

## Structure
- Package pipe_pkg: function for the occupancy width, default CNT_W constant, helper function popcount.
- Sub-module pipe_stage (WIDTH, CLEAR_DATA): one register with valid, en (=~hold), clr (=flush | bubble), async reset.
- Top: generate loop of DEPTH pipe_stage instances, hold-chain logic, bubble counter, occupancy.

## Test plan
- Free flow, DEPTH=4: in_data=1,2,3,… with in_valid=1 → out_data=1 on the 4th edge after the first input; then 2,3,… every cycle; occupancy=4.
- stall[1]=1 for 2 cycles with a full pipe → stages 0,1 frozen, in_ready=0, stages 2,3 drain. Stage 2 gets 2 bubbles; bubble_cnt=2; after release the order is preserved with no loss or duplication.
- flush=4'b0011 with a full pipe → next cycle stage_valid=4'b1100, stage_data[0],[1]=0; bubble_cnt unchanged.
- stall[2]=1 and flush[2]=1 together → stage 2 invalid next cycle; stages 0,1 still held; stage 3 receives a bubble (bubble_cnt+1).
- Async reset pulse mid-stream, between edges → all outputs 0 immediately; first payload after release emerges after 4 edges.
- CNT_W=2, continuous stall[0]=1 with no flush → bubble_cnt saturates at 3 and stays.
